// File: rtl/mem_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// port index constants and default bus widths.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Port 0 is the 6502 core, port 1 the loader/debug master.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 16;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-request winner select. pref_i names the port that wins
// a tie; a lone request always wins. Grant is one-hot or zero.
module mem_arb_pick (
  input  logic [1:0] req_i,
  input  logic       pref_i,
  output logic [1:0] gnt_o
);

  // Tie goes to the preferred port, otherwise the only requester wins.
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0] && req_i[1]) begin
      gnt_o = pref_i ? 2'b10 : 2'b01;
    end else if (req_i[0]) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single memory controller. One transaction
// at a time: IDLE -> ISSUE (strobe) -> WAIT (busy) -> DONE (completion pulse).
// Build option MEM_ARB_RR_EN: round-robin tie breaking with a pointer that
// moves to the other port after every DONE. Without it port 0 always wins.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int ADDR_WIDTH = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_done,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_done,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  mem_rd_enable,
  output logic                  mem_wr_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_busy,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  state_e                  state_q, state_d;
  logic                    win_q, win_d;
  logic                    we_q, we_d;
  logic                    first_q, first_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   p0_rdata_q, p0_rdata_d;
  logic [DATA_WIDTH-1:0]   p1_rdata_q, p1_rdata_d;
  logic                    pref;
  logic [1:0]              pick;

`ifdef MEM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Pointer hands preference to the port that did not just complete.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == DONE) ptr_d = ~win_q;
  end

  // Pointer register, starts out favouring the CPU.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= PORT_CPU;
    else        ptr_q <= ptr_d;
  end

  assign pref = ptr_q;
`else
  assign pref = PORT_CPU;
`endif

  mem_arb_pick u_pick (
    .req_i  ({p1_req, p0_req}),
    .pref_i (pref),
    .gnt_o  (pick)
  );

  // Next-state logic: launch in IDLE, skip busy on the first WAIT cycle
  // (controller has only just registered the strobe), finish on busy low.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    we_d       = we_q;
    first_d    = first_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    case (state_q)
      IDLE: begin
        if (|pick) begin
          state_d = ISSUE;
          win_d   = pick[1];
          if (pick[1]) begin
            we_d    = p1_we;
            addr_d  = p1_addr;
            wdata_d = p1_wdata;
          end else begin
            we_d    = p0_we;
            addr_d  = p0_addr;
            wdata_d = p0_wdata;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        first_d = 1'b1;
      end
      WAIT: begin
        if (first_q) begin
          first_d = 1'b0;
        end else if (!mem_busy) begin
          state_d = DONE;
          if (!we_q) begin
            if (win_q == PORT_AUX) p1_rdata_d = mem_rd_data;
            else                   p0_rdata_d = mem_rd_data;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      win_q      <= PORT_CPU;
      we_q       <= 1'b0;
      first_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      we_q       <= we_d;
      first_q    <= first_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  assign p0_gnt        = (state_q != IDLE) && (win_q == PORT_CPU);
  assign p1_gnt        = (state_q != IDLE) && (win_q == PORT_AUX);
  assign p0_done       = (state_q == DONE) && (win_q == PORT_CPU);
  assign p1_done       = (state_q == DONE) && (win_q == PORT_AUX);
  assign mem_rd_enable = (state_q == ISSUE) && !we_q;
  assign mem_wr_enable = (state_q == ISSUE) && we_q;
  assign mem_addr      = addr_q;
  assign mem_wr_data   = wdata_q;
  assign p0_rdata      = p0_rdata_q;
  assign p1_rdata      = p1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory controller
// whose busy period length is adjustable. Expectations follow the build
// option MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p1_addr;
  logic [7:0]  p0_wdata, p1_wdata;
  logic        p0_gnt, p0_done, p1_gnt, p1_done;
  logic [7:0]  p0_rdata, p1_rdata;
  logic        mem_rd_enable, mem_wr_enable, mem_busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wr_data;
  logic [7:0]  mem_rd_data = 8'h00;

  int total = 0;
  int bad   = 0;

  // memory model state
  logic [7:0]  mem_arr [0:65535];
  int          busy_len = 1;
  int          cnt = 0;
  int          rd_strobes = 0;
  int          wr_strobes = 0;
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = 16'h0;
  logic [7:0]  poke_data = 8'h0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .mem_rd_enable(mem_rd_enable), .mem_wr_enable(mem_wr_enable),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_busy(mem_busy), .mem_rd_data(mem_rd_data)
  );

  // Controller model: a strobe starts a busy period of busy_len cycles.
  always @(posedge clk) begin
    if (cnt > 0) cnt <= cnt - 1;
    if (poke_en) mem_arr[poke_addr] <= poke_data;
    if (mem_rd_enable) begin
      mem_rd_data <= mem_arr[mem_addr];
      cnt         <= busy_len;
      rd_strobes  <= rd_strobes + 1;
    end
    if (mem_wr_enable) begin
      mem_arr[mem_addr] <= mem_wr_data;
      cnt               <= busy_len;
      wr_strobes        <= wr_strobes + 1;
    end
  end
  assign mem_busy = (cnt != 0);

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Runs one transaction on a port; lat counts cycles from the sampling edge
  // to the done cycle (-1 if it never came).
  task automatic run_txn(input logic port, input logic we, input logic [15:0] a,
                         input logic [7:0] wd, output int lat, output logic [7:0] rd,
                         output int other, output int rd_s, output int wr_s);
    int r0, w0;
    @(negedge clk);
    r0 = rd_strobes; w0 = wr_strobes; lat = -1; other = 0; rd = 8'h00;
    if (port) begin p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = wd; end
    else      begin p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = wd; end
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (port ? (p0_gnt || p0_done) : (p1_gnt || p1_done)) other++;
      if (port ? p1_done : p0_done) begin
        lat = k;
        rd  = port ? p1_rdata : p0_rdata;
        break;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    rd_s = rd_strobes - r0;
    wr_s = wr_strobes - w0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    @(negedge clk);
    total++; if ({p0_gnt, p1_gnt} !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", {p0_gnt, p1_gnt}); end
    total++; if ({p0_done, p1_done} !== 2'b00) begin bad++; $display("FAIL reset_done: got %b want 00", {p0_done, p1_done}); end
    total++; if ({mem_rd_enable, mem_wr_enable} !== 2'b00) begin bad++; $display("FAIL reset_strobe: got %b want 00", {mem_rd_enable, mem_wr_enable}); end
    total++; if (mem_addr !== 16'h0) begin bad++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
    total++; if (mem_wr_data !== 8'h0) begin bad++; $display("FAIL reset_wdata: got %h want 00", mem_wr_data); end
    total++; if ({p0_rdata, p1_rdata} !== 16'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0000", {p0_rdata, p1_rdata}); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    int lat, other, rs, ws; logic [7:0] rd;
    poke(16'h1234, 8'hA5);
    run_txn(1'b0, 1'b0, 16'h1234, 8'h00, lat, rd, other, rs, ws);
    total++; if (lat !== 4) begin bad++; $display("FAIL read_latency: got %0d want 4", lat); end
    total++; if (rd !== 8'hA5) begin bad++; $display("FAIL read_data: got %h want a5", rd); end
    total++; if (rs !== 1 || ws !== 0) begin bad++; $display("FAIL read_strobes: got rd=%0d wr=%0d want rd=1 wr=0", rs, ws); end
    total++; if (other !== 0) begin bad++; $display("FAIL read_p1_quiet: got %0d want 0", other); end
    total++; if (p1_rdata !== 8'h00) begin bad++; $display("FAIL read_p1_rdata: got %h want 00", p1_rdata); end
    @(negedge clk);
    total++; if (p0_gnt !== 1'b0 || p0_done !== 1'b0) begin bad++; $display("FAIL read_release: got gnt=%b done=%b want 0 0", p0_gnt, p0_done); end
  endtask

  task automatic test_write_read();
    int lat, other, rs, ws; logic [7:0] rd, prev;
    prev = p1_rdata;
    run_txn(1'b1, 1'b1, 16'h0200, 8'h5A, lat, rd, other, rs, ws);
    total++; if (lat !== 4) begin bad++; $display("FAIL write_latency: got %0d want 4", lat); end
    total++; if (ws !== 1 || rs !== 0) begin bad++; $display("FAIL write_strobes: got rd=%0d wr=%0d want rd=0 wr=1", rs, ws); end
    total++; if (rd !== prev) begin bad++; $display("FAIL write_rdata_kept: got %h want %h", rd, prev); end
    @(negedge clk);
    total++; if (mem_addr !== 16'h0200 || mem_wr_data !== 8'h5A) begin bad++; $display("FAIL write_hold: got %h/%h want 0200/5a", mem_addr, mem_wr_data); end
    total++; if (mem_arr[16'h0200] !== 8'h5A) begin bad++; $display("FAIL write_mem: got %h want 5a", mem_arr[16'h0200]); end
    run_txn(1'b1, 1'b0, 16'h0200, 8'h00, lat, rd, other, rs, ws);
    total++; if (rd !== 8'h5A || lat !== 4) begin bad++; $display("FAIL readback: got %h lat=%0d want 5a lat=4", rd, lat); end
    total++; if (other !== 0) begin bad++; $display("FAIL readback_p0_quiet: got %0d want 0", other); end
  endtask

  task automatic test_simultaneous();
    int n, idx0, idx1, p1_seen, both;
    logic exp_port;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      poke(16'h0010 + 16'(k), 8'h10 + 8'(k));
      poke(16'h0020 + 16'(k), 8'h80 + 8'(k));
    end
    n = 0; idx0 = 0; idx1 = 0; p1_seen = 0; both = 0;
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0010;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0020;
    for (int c = 0; c < 200 && n < 6; c++) begin
      @(negedge clk);
      if (p1_gnt) p1_seen++;
      if (p0_gnt && p1_gnt) both++;
`ifdef MEM_ARB_RR_EN
      exp_port = n[0];
`else
      exp_port = 1'b0;
`endif
      if (p0_done || p1_done) begin
        total++; if (p1_done !== exp_port) begin bad++; $display("FAIL tie_order[%0d]: got port %b want port %b", n, p1_done, exp_port); end
        if (p0_done) begin
          total++; if (p0_rdata !== 8'h10 + 8'(idx0)) begin bad++; $display("FAIL tie_p0_data[%0d]: got %h want %h", idx0, p0_rdata, 8'h10 + 8'(idx0)); end
          idx0++; p0_addr = 16'h0010 + 16'(idx0);
        end else begin
          total++; if (p1_rdata !== 8'h80 + 8'(idx1)) begin bad++; $display("FAIL tie_p1_data[%0d]: got %h want %h", idx1, p1_rdata, 8'h80 + 8'(idx1)); end
          idx1++; p1_addr = 16'h0020 + 16'(idx1);
        end
        n++;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    total++; if (n !== 6) begin bad++; $display("FAIL tie_count: got %0d want 6", n); end
    total++; if (both !== 0) begin bad++; $display("FAIL tie_onehot: got %0d want 0", both); end
`ifndef MEM_ARB_RR_EN
    total++; if (p1_seen !== 0) begin bad++; $display("FAIL tie_p1_starved: got %0d want 0", p1_seen); end
`endif
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stretched_busy();
    int lat, other, rs, ws; logic [7:0] rd;
    busy_len = 7;
    poke(16'h0300, 8'h3C);
    run_txn(1'b0, 1'b0, 16'h0300, 8'h00, lat, rd, other, rs, ws);
    total++; if (lat !== 10) begin bad++; $display("FAIL stretch_latency: got %0d want 10", lat); end
    total++; if (rd !== 8'h3C) begin bad++; $display("FAIL stretch_data: got %h want 3c", rd); end
    total++; if (rs !== 1 || ws !== 0) begin bad++; $display("FAIL stretch_strobes: got rd=%0d wr=%0d want rd=1 wr=0", rs, ws); end
    @(negedge clk);
    total++; if (p0_done !== 1'b0) begin bad++; $display("FAIL stretch_done_pulse: got %b want 0", p0_done); end
    busy_len = 1;
  endtask

  task automatic test_reset_mid_wait();
    int lat;
    poke(16'h0400, 8'h77);
    @(negedge clk);
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0400;
    repeat (2) @(negedge clk);
    total++; if (p1_gnt !== 1'b1) begin bad++; $display("FAIL midwait_gnt_before: got %b want 1", p1_gnt); end
    reset = 1'b0;
    #1;
    total++; if ({p1_gnt, p1_done, mem_rd_enable, mem_wr_enable} !== 4'b0000) begin bad++; $display("FAIL midwait_abort: got %b want 0000", {p1_gnt, p1_done, mem_rd_enable, mem_wr_enable}); end
    @(negedge clk);
    total++; if (p1_done !== 1'b0) begin bad++; $display("FAIL midwait_no_done: got %b want 0", p1_done); end
    reset = 1'b1;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (p1_done) begin lat = k; break; end
    end
    total++; if (lat !== 4) begin bad++; $display("FAIL midwait_restart_latency: got %0d want 4", lat); end
    total++; if (p1_rdata !== 8'h77) begin bad++; $display("FAIL midwait_restart_data: got %h want 77", p1_rdata); end
    p1_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_stretched_busy();
    test_reset_mid_wait();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single memory controller (memory controller plus block RAM) between the 6502 core (port 0) and a secondary master such as a program loader or debug port (port 1). It accepts one-transaction-at-a-time requests from each port, picks a winner, launches one read or write to the controller, waits out the controller's busy period, and returns completion and read data to the winning port. It sits between the requesters and the memory top-level, driving its read enable, write enable, address and write-data inputs and observing its busy and read-data outputs.

## Interface
- DATA_WIDTH, 8, data bus width
- ADDR_WIDTH, 16, address bus width
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- p0_req / p1_req  in  1  request; held high with payload stable until that port's done pulse
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  ADDR_WIDTH  address
- p0_wdata / p1_wdata  in  DATA_WIDTH  write data
- p0_gnt / p1_gnt  out  1  high from issue until done, inclusive; one-hot or zero
- p0_done / p1_done  out  1  one-cycle completion pulse
- p0_rdata / p1_rdata  out  DATA_WIDTH  read data, valid in the done cycle, held until next done on that port
- mem_rd_enable  out  1  one-cycle read strobe to memory
- mem_wr_enable  out  1  one-cycle write strobe to memory
- mem_addr  out  ADDR_WIDTH  registered address
- mem_wr_data  out  DATA_WIDTH  registered write data
- mem_busy  in  1  memory busy
- mem_rd_data  in  DATA_WIDTH  memory read data, valid when busy falls

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req high, choose winner, latch its we/addr/wdata into mem_* registers, assert winner gnt, go ISSUE. Otherwise stay.
- ISSUE (one cycle): pulse mem_rd_enable (we=0) or mem_wr_enable (we=1); go WAIT.
- WAIT: first WAIT cycle ignores mem_busy (controller registers strobe). From the second WAIT cycle on, busy sampled low -> capture mem_rd_data into winner's rdata (reads only), go DONE.
- DONE (one cycle): winner done=1, gnt=1; next state IDLE; gnt drops.
- Writes leave pN_rdata unchanged.
- Requester that keeps req high after done re-enters arbitration in IDLE next cycle.
- req dropping before done is illegal; arbiter completes the transaction regardless.
- mem_addr/mem_wr_data hold last value outside transactions; strobes never high outside ISSUE.

## Timing
- Reset (reset=0): state IDLE, all gnt/done/strobes 0, mem_addr 0, mem_wr_data 0, both rdata 0, priority pointer to port 0. Reset mid-transaction aborts immediately; no done issued.
- req sampled high in IDLE at edge N -> gnt high cycle N+1 (ISSUE, strobe high). WAIT from N+2.
- With controller busy high exactly one cycle (N+2), busy low sampled at N+3 -> DONE at N+4 with rdata valid. Minimum req-to-done 4 cycles, back-to-back throughput one transaction per 5 cycles.
- Simultaneous requests in IDLE: resolved per Configuration; loser's req stays pending, no lost request.
- Busy stuck high: arbiter waits indefinitely (no timeout).

## Configuration
- MEM_ARB_RR_EN defined: round-robin. Pointer names preferred port; on a tie the preferred port wins, pointer then moves to the other port after each DONE. Guarantees each port at most one foreign transaction between its own.
- Undefined: fixed priority, port 0 (CPU) always wins ties; port 1 may starve. Pointer register not built.

## Structure
- Shared package mem_pkg: state enum (IDLE, ISSUE, WAIT, DONE), port index constants PORT_CPU=0, PORT_AUX=1, default widths.
- One sub-module: mem_arb_pick — combinational two-request winner select taking reqs and pointer, returning one-hot grant; the RR/fixed choice is confined to it plus the pointer register.

## Test plan
- Single read: memory[0x1234]=0xA5, p0 read 0x1234 -> mem_rd_enable one cycle, p0_done 4 cycles after req, p0_rdata=0xA5, p1 signals untouched.
- Write then read: p1 writes 0x5A to 0x0200, then reads 0x0200 -> p1_rdata=0x5A; p1_rdata unchanged after the write's done.
- Simultaneous requests, fixed priority: p0 and p1 req held high for 6 transactions -> all grants to p0, p1_gnt never asserts.
- Simultaneous requests, MEM_ARB_RR_EN: same stimulus -> grants alternate p0,p1,p0,p1,...; each done matches its address/data.
- Stretched busy: model holds mem_busy high 7 cycles -> done exactly one cycle after busy sampled low, no second strobe.
- Reset mid-WAIT: assert reset=0 during WAIT -> gnt, done, strobes 0 immediately; after release, pending req restarts cleanly from IDLE.
